// File: rtl/dispatch_int.sv
// Integer dispatch stage: one group register feeding the issue queue, plus a PRF busy table for operand readiness.
// One cycle capture-to-dispatch; iq_int_full holds the group and drops in_ready so rename must hold.
package dispatch_int_pkg;
    localparam int UOP_PRF_INDEX_SIZE = 6;

    typedef struct packed {
        logic                          valid;
        logic                          rs1_valid;
        logic [UOP_PRF_INDEX_SIZE-1:0] rs1;
        logic                          rs2_valid;
        logic [UOP_PRF_INDEX_SIZE-1:0] rs2;
        logic                          rd_valid;
        logic [UOP_PRF_INDEX_SIZE-1:0] rd;
        logic [15:0]                   payload;
    } micro_op_t;
endpackage

module dispatch_int
    import dispatch_int_pkg::*;
#(
    parameter int DISPATCH_WIDTH  = 4,
    parameter int ISSUE_WIDTH_INT = 3,
    parameter int PRF_INT_SIZE    = 64,
    localparam int PRF_INT_INDEX_SIZE = $clog2(PRF_INT_SIZE)
) (
    input  logic                                               clock,
    input  logic                                               reset,
    input  logic                                               flush,
    input  micro_op_t [DISPATCH_WIDTH-1:0]                     uop_in,
    output logic                                               in_ready,
    input  logic [ISSUE_WIDTH_INT-1:0][PRF_INT_INDEX_SIZE-1:0] ctb_prf_int_index,
    input  logic [ISSUE_WIDTH_INT-1:0]                         ctb_valid,
    input  logic                                               iq_int_full,
    output micro_op_t [DISPATCH_WIDTH-1:0]                     uop_out,
    output logic [DISPATCH_WIDTH-1:0]                          rs1_from_ctb,
    output logic [DISPATCH_WIDTH-1:0]                          rs2_from_ctb,
    output logic [31:0]                                        stall_count
);

    micro_op_t [DISPATCH_WIDTH-1:0] held_q;
    logic [PRF_INT_SIZE-1:0]        busy_q;
    logic [PRF_INT_SIZE-1:0]        busy_nxt;
    logic                           held_valid;
    logic                           dispatch;

    function automatic logic ctb_hit(
        input logic [ISSUE_WIDTH_INT-1:0]                         vld,
        input logic [ISSUE_WIDTH_INT-1:0][PRF_INT_INDEX_SIZE-1:0] idx,
        input logic [PRF_INT_INDEX_SIZE-1:0]                      tag
    );
        ctb_hit = 1'b0;
        for (int k = 0; k < ISSUE_WIDTH_INT; k++) begin
            if (vld[k] && idx[k] == tag) ctb_hit = 1'b1;
        end
    endfunction

    always_comb begin
        held_valid = 1'b0;
        for (int i = 0; i < DISPATCH_WIDTH; i++) held_valid |= held_q[i].valid;
    end

    assign in_ready = ~held_valid | ~iq_int_full;
    assign dispatch = held_valid & ~iq_int_full;
    assign uop_out  = dispatch ? held_q : '0;

    // A source waits if its producer is still in flight and not landing this cycle,
    // or if an older slot of the same group writes it.
    always_comb begin
        logic older1;
        logic older2;
        rs1_from_ctb = '0;
        rs2_from_ctb = '0;
        for (int i = 0; i < DISPATCH_WIDTH; i++) begin
            older1 = 1'b0;
            older2 = 1'b0;
            for (int j = 0; j < i; j++) begin
                if (uop_out[j].rd_valid && uop_out[j].rd == uop_out[i].rs1) older1 = 1'b1;
                if (uop_out[j].rd_valid && uop_out[j].rd == uop_out[i].rs2) older2 = 1'b1;
            end
            rs1_from_ctb[i] = uop_out[i].valid & uop_out[i].rs1_valid & (uop_out[i].rs1 != '0) &
                              ((busy_q[uop_out[i].rs1] &
                                ~ctb_hit(ctb_valid, ctb_prf_int_index, uop_out[i].rs1)) | older1);
            rs2_from_ctb[i] = uop_out[i].valid & uop_out[i].rs2_valid & (uop_out[i].rs2 != '0) &
                              ((busy_q[uop_out[i].rs2] &
                                ~ctb_hit(ctb_valid, ctb_prf_int_index, uop_out[i].rs2)) | older2);
        end
    end

    // Sets are applied after clears so a same-cycle dispatch wins over write-back.
    always_comb begin
        busy_nxt = busy_q;
        for (int k = 0; k < ISSUE_WIDTH_INT; k++) begin
            if (ctb_valid[k]) busy_nxt[ctb_prf_int_index[k]] = 1'b0;
        end
        for (int i = 0; i < DISPATCH_WIDTH; i++) begin
            if (uop_out[i].valid && uop_out[i].rd_valid && uop_out[i].rd != '0)
                busy_nxt[uop_out[i].rd] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            held_q      <= '0;
            busy_q      <= '0;
            stall_count <= '0;
        end else begin
            if (flush) begin
                held_q <= '0;
                busy_q <= '0;
            end else begin
                if (in_ready) held_q <= uop_in;
                busy_q <= busy_nxt;
            end
            if (held_valid && iq_int_full && stall_count != 32'hFFFF_FFFF)
                stall_count <= stall_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_dispatch_int.sv
// Scoreboarded bench for dispatch_int: directed scenarios then randomized traffic against a cycle-level reference model.
`timescale 1ns/1ps
module tb_dispatch_int;
    import dispatch_int_pkg::*;

    localparam int DW  = 4;
    localparam int IW  = 3;
    localparam int PRF = 64;
    localparam int IDX = 6;

    logic                    clock = 1'b0;
    logic                    reset;
    logic                    flush;
    micro_op_t [DW-1:0]      uop_in;
    logic                    in_ready;
    logic [IW-1:0][IDX-1:0]  ctb_prf_int_index;
    logic [IW-1:0]           ctb_valid;
    logic                    iq_int_full;
    micro_op_t [DW-1:0]      uop_out;
    logic [DW-1:0]           rs1_from_ctb;
    logic [DW-1:0]           rs2_from_ctb;
    logic [31:0]             stall_count;

    always #5 clock = ~clock;

    dispatch_int #(
        .DISPATCH_WIDTH (DW),
        .ISSUE_WIDTH_INT(IW),
        .PRF_INT_SIZE   (PRF)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .flush            (flush),
        .uop_in           (uop_in),
        .in_ready         (in_ready),
        .ctb_prf_int_index(ctb_prf_int_index),
        .ctb_valid        (ctb_valid),
        .iq_int_full      (iq_int_full),
        .uop_out          (uop_out),
        .rs1_from_ctb     (rs1_from_ctb),
        .rs2_from_ctb     (rs2_from_ctb),
        .stall_count      (stall_count)
    );

    typedef struct {
        micro_op_t [DW-1:0] grp;
        logic [DW-1:0]      r1;
        logic [DW-1:0]      r2;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model state: the group waiting to leave, pending registers, stall cycles.
    micro_op_t [DW-1:0] m_held;
    bit                 m_has;
    bit                 m_busy[PRF];
    logic [31:0]        m_stall;

    micro_op_t [DW-1:0]     s_grp;
    logic                   s_full;
    logic                   s_flush;
    logic [IW-1:0]          s_cv;
    logic [IW-1:0][IDX-1:0] s_ci;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit landing(input logic [IDX-1:0] r);
        for (int k = 0; k < IW; k++) if (s_cv[k] && s_ci[k] == r) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit waits(input micro_op_t [DW-1:0] g, input int i, input bit second);
        logic [IDX-1:0] r;
        bit             v;
        r = second ? g[i].rs2 : g[i].rs1;
        v = second ? g[i].rs2_valid : g[i].rs1_valid;
        if (!g[i].valid || !v || r == 0) return 1'b0;
        if (m_busy[r] && !landing(r)) return 1'b1;
        for (int j = 0; j < i; j++) if (g[j].rd_valid && g[j].rd == r) return 1'b1;
        return 1'b0;
    endfunction

    function automatic micro_op_t mk(input bit rdv, input int rd, input bit r1v, input int r1,
                                     input bit r2v, input int r2);
        micro_op_t u;
        u           = '0;
        u.valid     = 1'b1;
        u.rd_valid  = rdv;
        u.rd        = IDX'(rd);
        u.rs1_valid = r1v;
        u.rs1       = IDX'(r1);
        u.rs2_valid = r2v;
        u.rs2       = IDX'(r2);
        u.payload   = 16'($urandom);
        return u;
    endfunction

    function automatic micro_op_t rand_uop();
        micro_op_t u;
        u = '0;
        if ($urandom_range(0, 9) < 7)
            u = mk(1'($urandom_range(0, 1)), $urandom_range(0, 15), 1'($urandom_range(0, 1)),
                   $urandom_range(0, 15), 1'($urandom_range(0, 1)), $urandom_range(0, 15));
        return u;
    endfunction

    task automatic idle();
        s_grp = '0; s_full = 1'b0; s_flush = 1'b0; s_cv = '0; s_ci = '0;
    endtask

    task automatic model_reset();
        m_has = 1'b0; m_held = '0; m_stall = '0;
        foreach (m_busy[r]) m_busy[r] = 1'b0;
    endtask

    // Apply one cycle of stimulus, predict, check the per-cycle outputs, then advance the model.
    task automatic step();
        exp_t e;
        bit   rdy;
        bit   disp;
        bit   anyv;
        @(posedge clock);
        #1;
        uop_in = s_grp; iq_int_full = s_full; flush = s_flush;
        ctb_valid = s_cv; ctb_prf_int_index = s_ci;
        rdy  = !m_has || !s_full;
        disp = m_has && !s_full;
        if (disp) begin
            e.grp = m_held; e.r1 = '0; e.r2 = '0;
            for (int i = 0; i < DW; i++) begin
                e.r1[i] = waits(m_held, i, 1'b0);
                e.r2[i] = waits(m_held, i, 1'b1);
            end
            sb.push_back(e);
        end
        @(negedge clock);
        check("in_ready", 256'(in_ready), 256'(rdy));
        check("stall_count", 256'(stall_count), 256'(m_stall));
        if (m_has && s_full && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
        if (s_flush) begin
            m_has = 1'b0;
            foreach (m_busy[r]) m_busy[r] = 1'b0;
        end else begin
            for (int k = 0; k < IW; k++) if (s_cv[k]) m_busy[s_ci[k]] = 1'b0;
            if (disp)
                for (int i = 0; i < DW; i++)
                    if (m_held[i].valid && m_held[i].rd_valid && m_held[i].rd != 0)
                        m_busy[m_held[i].rd] = 1'b1;
            if (rdy) begin
                anyv = 1'b0;
                for (int i = 0; i < DW; i++) anyv |= s_grp[i].valid;
                m_has  = anyv;
                m_held = s_grp;
            end
        end
    endtask

    initial begin : monitor
        exp_t e;
        bit   anyv;
        forever begin
            @(negedge clock);
            anyv = 1'b0;
            for (int i = 0; i < DW; i++) anyv |= uop_out[i].valid;
            if (anyv) begin
                if (sb.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_dispatch: got %0h expected no group", uop_out);
                end else begin
                    e = sb.pop_front();
                    check("uop_out", 256'(uop_out), 256'(e.grp));
                    check("rs1_from_ctb", 256'(rs1_from_ctb), 256'(e.r1));
                    check("rs2_from_ctb", 256'(rs2_from_ctb), 256'(e.r2));
                end
            end else begin
                check("idle_outputs", 256'({uop_out, rs1_from_ctb, rs2_from_ctb}), 256'(0));
            end
        end
    end

    initial begin : stimulus
        reset = 1'b0; flush = 1'b0; iq_int_full = 1'b0; uop_in = '0;
        ctb_valid = '0; ctb_prf_int_index = '0;
        idle();
        model_reset();
        #12;
        check("reset_in_ready", 256'(in_ready), 256'(1));
        check("reset_stall_count", 256'(stall_count), 256'(0));
        check("reset_uop_out", 256'(uop_out), 256'(0));
        reset = 1'b1;

        // intra-group dependency, then set busy[5]
        idle(); s_grp[0] = mk(1, 5, 0, 0, 0, 0); s_grp[1] = mk(0, 0, 1, 5, 0, 0); step();
        idle(); step();
        // consumer of 5 dispatched while CTB port 2 delivers 5
        idle(); s_grp[0] = mk(0, 0, 1, 5, 0, 0); step();
        idle(); s_cv = 3'b100; s_ci[2] = 6'd5; step();
        idle(); s_grp[0] = mk(0, 0, 0, 0, 1, 5); step();
        idle(); step();
        // three-cycle stall, group emitted unchanged afterwards
        idle(); s_grp[0] = mk(1, 3, 1, 2, 1, 4); s_grp[2] = mk(0, 0, 1, 3, 0, 0); step();
        for (int n = 0; n < 3; n++) begin idle(); s_full = 1'b1; s_grp[0] = mk(0, 0, 0, 0, 0, 0); step(); end
        idle(); step();
        // set wins over same-cycle clear on 7
        idle(); s_grp[0] = mk(1, 7, 0, 0, 0, 0); step();
        idle(); s_cv = 3'b001; s_ci[0] = 6'd7; step();
        idle(); s_grp[1] = mk(0, 0, 1, 7, 1, 7); step();
        idle(); step();
        // flush drops a stalled group and the busy table, keeps stall_count
        idle(); s_grp[0] = mk(1, 9, 0, 0, 0, 0); step();
        idle(); step();
        idle(); s_grp[0] = mk(0, 0, 1, 2, 0, 0); step();
        idle(); s_full = 1'b1; s_flush = 1'b1; step();
        idle(); s_grp[0] = mk(0, 0, 1, 9, 0, 0); step();
        idle(); step();

        for (int n = 0; n < 2000; n++) begin
            for (int i = 0; i < DW; i++) s_grp[i] = rand_uop();
            s_full  = ($urandom_range(0, 9) < 4);
            s_flush = ($urandom_range(0, 99) < 3);
            for (int k = 0; k < IW; k++) begin
                s_cv[k] = 1'($urandom_range(0, 1));
                s_ci[k] = IDX'($urandom_range(0, 15));
            end
            step();
        end

        // asynchronous reset in the middle of a stall
        idle(); s_grp[0] = mk(1, 4, 0, 0, 0, 0); step();
        idle(); s_full = 1'b1; step();
        idle(); s_full = 1'b1; step();
        #2 reset = 1'b0;
        #1;
        check("async_in_ready", 256'(in_ready), 256'(1));
        check("async_uop_out", 256'(uop_out), 256'(0));
        check("async_rs_flags", 256'({rs1_from_ctb, rs2_from_ctb}), 256'(0));
        check("async_stall_count", 256'(stall_count), 256'(0));
        model_reset();
        #1 reset = 1'b1;
        idle(); s_grp[0] = mk(0, 0, 1, 4, 0, 0); s_grp[1] = mk(1, 6, 0, 0, 0, 0); step();
        idle(); s_grp[0] = mk(0, 0, 1, 6, 0, 0); step();
        idle(); step();
        idle(); step();
        check("scoreboard_drained", 256'(sb.size()), 256'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dispatch_int.md
DISPATCH_INT -- requirements
Module: dispatch_int

Interface
REQ-001 SHALL have parameter DISPATCH_WIDTH, default 4, uops per rename group.
REQ-002 SHALL have parameter ISSUE_WIDTH_INT, default 3, number of common tag bus (CTB) write-back ports.
REQ-003 SHALL have parameter PRF_INT_SIZE, default 64, number of integer physical registers; PRF_INT_INDEX_SIZE = clog2(PRF_INT_SIZE).
REQ-004 SHALL have port clock  in  1  sole clock, rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port flush  in  1  synchronous pipeline flush.
REQ-007 SHALL have port uop_in  in  micro_op_t[DISPATCH_WIDTH]  renamed group; per-slot .valid.
REQ-008 SHALL have port in_ready  out  1  stage can accept a group this cycle.
REQ-009 SHALL have port ctb_prf_int_index  in  [ISSUE_WIDTH_INT][PRF_INT_INDEX_SIZE]  write-back tags.
REQ-010 SHALL have port ctb_valid  in  [ISSUE_WIDTH_INT]  tag valid per CTB port.
REQ-011 SHALL have port iq_int_full  in  1  issue queue cannot take a group.
REQ-012 SHALL have port uop_out  out  micro_op_t[DISPATCH_WIDTH]  group to issue queue.
REQ-013 SHALL have port rs1_from_ctb / rs2_from_ctb  out  [DISPATCH_WIDTH]  operand must wait for CTB.
REQ-014 SHALL have port stall_count  out  32  cycles a held group was blocked by iq_int_full.

Function
REQ-015 SHALL hold one group register (DISPATCH_WIDTH uops plus held_valid); held_valid = OR of captured uop .valid bits.
REQ-016 SHALL drive in_ready = ~held_valid | ~iq_int_full, combinationally.
REQ-017 SHALL capture uop_in on a rising edge when in_ready=1 and any uop_in[i].valid=1; when in_ready=1 and no input is valid, held_valid SHALL become 0.
REQ-018 SHALL keep the held group unchanged while held_valid=1 and iq_int_full=1. Input is ignored during this stall, and rename must hold.
REQ-019 SHALL drive uop_out = held group when held_valid=1 and iq_int_full=0, else all-zero (all .valid=0). This gives one cycle of latency from capture to dispatch.
REQ-020 SHALL keep a PRF_INT_SIZE-bit busy table; bit=1 means the value is pending write-back. Bit 0 SHALL be constant 0.
REQ-021 SHALL clear busy[ctb_prf_int_index[k]] at the edge for each k with ctb_valid[k]=1.
REQ-022 SHALL set busy[rd_prf_int_index] at the edge for each dispatched uop (uop_out[i].valid) with rd_valid=1 and rd index != 0.
REQ-023 SHALL let the set win when a set and a clear target the same index in the same cycle.
REQ-024 SHALL compute rs1_from_ctb[i] = uop.rs1_valid & rs1 index != 0 & (busy[rs1] & ~same-cycle CTB hit on rs1 | an older slot j<i in the group has rd_valid & rd == rs1). rs2_from_ctb SHALL be computed likewise.
REQ-025 SHALL drive rs1_from_ctb / rs2_from_ctb as 0 for any slot whose uop_out .valid=0.
REQ-026 SHALL increment stall_count each cycle with held_valid=1 and iq_int_full=1, saturating at 0xFFFF_FFFF. stall_count SHALL NOT be cleared by flush.
REQ-027 SHALL, on flush=1 at an edge, clear held_valid and all busy bits; flush SHALL take priority over capture, set and clear in that cycle. in_ready SHALL be unaffected combinationally.
REQ-028 SHALL set no busy bits while flush=1, and uop_out SHALL still follow REQ-019 in the flush cycle.

Reset
REQ-029 SHALL, while reset=0 (asynchronously), drive held_valid=0, all busy bits=0 and stall_count=0, giving outputs in_ready=1, uop_out all-zero, rs*_from_ctb=0.
REQ-030 SHALL resume normal operation at the first rising edge after reset deasserts, including when reset is asserted mid-stall.

Verification
REQ-031 Reset then group {slot0: rd=5, slot1: rs1=5}, iq_int_full=0 -> next cycle uop_out valid, rs1_from_ctb[1]=1 (intra-group), busy[5]=1 after the edge.
REQ-032 busy[5]=1, then new uop rs1=5 dispatched in the same cycle as ctb_valid[2]=1, ctb index=5 -> rs1_from_ctb=0, and busy[5]=0 after the edge.
REQ-033 Group held with iq_int_full=1 for 3 cycles -> in_ready=0, uop_out all-zero, stall_count=3, and the group is emitted unchanged when full drops.
REQ-034 Dispatch rd=7 while CTB clears index 7 in the same cycle -> busy[7]=1 afterwards (set wins).
REQ-035 Held group plus busy[9]=1, then flush=1 -> held_valid=0, busy all 0, stall_count retained; a later uop with rs1=9 gets rs1_from_ctb=0.
REQ-036 Assert reset=0 asynchronously mid-stall -> outputs immediately at reset values with no clock edge, and stall_count=0.
